inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, meaning PC loaded on reset.
REQ-002 Parameter XLEN, default 64, meaning PC/address width.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 redirect_valid  input  1  taken branch/jal/jalr/trap from execute, one-cycle pulse.
REQ-006 redirect_pc  input  XLEN  target PC, sampled when redirect_valid=1.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_req_addr  output  XLEN  fetch address.
REQ-010 imem_resp_valid  input  1  instruction word returned, never earlier than the cycle after request acceptance.
REQ-011 imem_resp_data  input  32  instruction word.
REQ-012 inst_valid  output  1  instruction presented to decoder.
REQ-013 inst_ready  input  1  decoder consumes instruction.
REQ-014 inst  output  32  instruction word to decoder.
REQ-015 inst_pc  output  XLEN  PC of presented instruction.
REQ-016 fetch_fault  output  1  presented slot is a misaligned-PC fault, not an instruction.

Function
REQ-017 FSM states REQ, WAIT, HOLD; exactly one request outstanding at most.
REQ-018 REQ: imem_req_valid=1, imem_req_addr=pc; on req_valid&req_ready -> WAIT; no handshake -> stay REQ.
REQ-019 WAIT: on imem_resp_valid with drop=0 -> latch data into inst, inst_pc<=pc, -> HOLD.
REQ-020 WAIT: on imem_resp_valid with drop=1 -> discard data, clear drop, -> REQ.
REQ-021 HOLD: inst_valid=1; on inst_ready -> pc<=pc+4 (mod 2^XLEN, wraps), -> REQ; next request issued the cycle after consume (fetch latency ≥ 2 cycles/instruction).
REQ-022 redirect_valid in any state: pc<=redirect_pc; redirect beats inst_ready in the same cycle.
REQ-023 Redirect in REQ with no request handshake that cycle -> stay REQ, next request uses redirect_pc.
REQ-024 Redirect in REQ coinciding with request handshake -> WAIT with drop=1.
REQ-025 Redirect in WAIT, no response that cycle -> drop=1, stay WAIT; with response that cycle -> discard response, drop=0, -> REQ.
REQ-026 Redirect in HOLD -> inst_valid deasserts next cycle, -> REQ.
REQ-027 Misaligned fetch (pc[1:0]!=0) in REQ: no memory request; -> HOLD with fetch_fault=1, inst=32'h0000_0013, inst_pc=pc; consumed/redirected like a normal slot; inst_ready without redirect -> pc<=pc+4.
REQ-028 inst, inst_pc, fetch_fault stable while inst_valid=1 and not consumed/redirected.
REQ-029 inst_valid=0 in REQ and WAIT; imem_req_valid=0 in WAIT and HOLD.

Reset
REQ-030 On rst: state=REQ, pc=RESET_PC, drop=0, inst=32'h0, inst_pc=0, fetch_fault=0, inst_valid=0.
REQ-031 Reset mid-request: outstanding response arriving after rst deassertion is discarded by the memory side; block issues a fresh request to RESET_PC the first cycle out of reset.

Structure
REQ-032 FSM state encoding, RESET_PC, NOP encoding 32'h0000_0013 live in the shared defines include alongside existing width macros.
REQ-033 Single flat module; no sub-module.

Verification
REQ-034 Reset release, memory ready, 1-cycle response 32'h00100093 -> req_addr=0x80000000, inst_valid with inst=0x00100093, inst_pc=0x80000000; consume -> next req_addr=0x80000004.
REQ-035 inst_ready held low 5 cycles in HOLD -> inst/inst_pc constant, no new request; ready high -> pc advances by 4.
REQ-036 Redirect to 0x80000100 while WAIT (response 3 cycles later) -> stale response discarded, next req_addr=0x80000100, inst_pc=0x80000100 on next presented slot.
REQ-037 Redirect and inst_ready same cycle in HOLD at pc 0x80000008, target 0x80000040 -> next req_addr=0x80000040, not 0x8000000C.
REQ-038 Redirect to 0x80000102 -> no imem request, fetch_fault=1, inst=0x00000013, inst_pc=0x80000102.
REQ-039 rst asserted during WAIT -> outputs take REQ-030 values immediately (asynchronous), first post-reset req_addr=0x80000000.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Holds the FSM state encoding, the default reset PC and the NOP encoding.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    localparam int          DEFAULT_XLEN     = 64;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

    // addi x0, x0, 0 -- presented in place of an instruction on a misaligned-PC fault
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch stage: REQ issues a memory request, WAIT
// collects the word, HOLD presents it to decode until it is consumed or redirected.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_fault
);

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic            drop_reg, drop_next;
    logic [31:0]     inst_reg, inst_next;
    logic [XLEN-1:0] inst_pc_reg, inst_pc_next;
    logic            fault_reg, fault_next;

    logic misaligned;
    logic req_fire;

    assign misaligned     = (pc_reg[1:0] != 2'b00);
    assign imem_req_valid = (state_reg == ST_REQ) && !misaligned;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign imem_req_addr  = pc_reg;
    assign inst_valid     = (state_reg == ST_HOLD);
    assign inst           = inst_reg;
    assign inst_pc        = inst_pc_reg;
    assign fetch_fault    = fault_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_REQ;
            pc_reg      <= RESET_PC;
            drop_reg    <= 1'b0;
            inst_reg    <= 32'h0;
            inst_pc_reg <= '0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            drop_reg    <= drop_next;
            inst_reg    <= inst_next;
            inst_pc_reg <= inst_pc_next;
            fault_reg   <= fault_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        drop_next    = drop_reg;
        inst_next    = inst_reg;
        inst_pc_next = inst_pc_reg;
        fault_next   = fault_reg;

        case (state_reg)
            ST_REQ: begin
                if (redirect_valid) begin
                    // A request accepted in the redirect cycle is already stale.
                    pc_next = redirect_pc;
                    if (req_fire) begin
                        state_next = ST_WAIT;
                        drop_next  = 1'b1;
                    end
                end else if (misaligned) begin
                    state_next   = ST_HOLD;
                    inst_next    = NOP_INST;
                    inst_pc_next = pc_reg;
                    fault_next   = 1'b1;
                end else if (req_fire) begin
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                    if (imem_resp_valid) begin
                        drop_next  = 1'b0;
                        state_next = ST_REQ;
                    end else begin
                        drop_next = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop_reg) begin
                        drop_next  = 1'b0;
                        state_next = ST_REQ;
                    end else begin
                        inst_next    = imem_resp_data;
                        inst_pc_next = pc_reg;
                        fault_next   = 1'b0;
                        state_next   = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                // Redirect wins over a same-cycle consume.
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = ST_REQ;
                end else if (inst_ready) begin
                    pc_next    = pc_reg + XLEN'(4);
                    state_next = ST_REQ;
                end
            end

            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic, checked every
// cycle against an architectural model of the fetch PC and a single-slot memory.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int          XLEN = 64;
    localparam logic [63:0] RPC  = 64'h0000_0000_8000_0000;

    logic            clk;
    logic            rst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            fetch_fault;

    inst_fetch #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .fetch_fault     (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          slots    = 0;
    logic [63:0] m_pc     = RPC;
    bit          m_out    = 1'b0;
    bit          rand_on  = 1'b0;
    int          lat      = 1;
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [63:0] mem_addr = '0;

    // Memory contents: a fixed word at the reset PC, a scrambled address elsewhere.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0010_0093;
        return (a[31:0] * 32'h9E37_79B1) ^ {a[63:32]} ^ 32'h0000_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        t = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
        if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    // One clock cycle: compare and advance the model at the falling edge, then
    // drive memory response and stimulus just after the rising edge.
    task automatic step();
        bit hs;
        @(negedge clk);
        hs = 1'b0;
        if (rst) begin
            m_pc  = RPC;
            m_out = 1'b0;
        end else begin
            if (imem_req_valid) begin
                chk("req_addr", imem_req_addr, m_pc);
                chk("req_single_outstanding", 64'(m_out), 64'd0);
                chk("req_aligned", 64'(m_pc[1:0]), 64'd0);
                chk("req_excl_slot", 64'(inst_valid), 64'd0);
            end
            if (inst_valid) begin
                bit flt;
                flt = (m_pc[1:0] != 2'b00);
                chk("slot_pc", inst_pc, m_pc);
                chk("slot_fault", 64'(fetch_fault), 64'(flt));
                chk("slot_inst", 64'(inst), 64'(flt ? NOP_INST : mem_word(m_pc)));
            end
            if (imem_resp_valid) m_out = 1'b0;
            hs = imem_req_valid && imem_req_ready;
            if (hs) begin
                m_out    = 1'b1;
                mem_addr = imem_req_addr;
            end
            if (redirect_valid) m_pc = redirect_pc;
            else if (inst_valid && inst_ready) begin
                m_pc = m_pc + 64'd4;
                slots++;
            end
        end
        @(posedge clk);
        #2;
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        redirect_valid  = 1'b0;
        redirect_pc     = {$urandom, $urandom};
        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (hs) begin
                mem_pend = 1'b1;
                mem_cnt  = lat;
            end
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt <= 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(mem_addr);
                    mem_pend        = 1'b0;
                end
            end
        end
        if (rand_on) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            lat            = int'($urandom_range(1, 4));
            if ($urandom_range(0, 11) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = rand_target();
            end
        end
    endtask

    // Steps until the request (want_slot=0) or a presented slot (want_slot=1) is visible.
    task automatic wait_for(input bit want_slot, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            hit = want_slot ? inst_valid : imem_req_valid;
            if (!hit) step();
        end
        chk(name, 64'(hit), 64'd1);
    endtask

    task automatic consume();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready      = 1'b0;
        repeat (2) step();

        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_fault", 64'(fetch_fault), 64'd0);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rst_req_addr", imem_req_addr, 64'h8000_0000);

        // First fetch with a one-cycle memory.
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        lat            = 1;
        wait_for(1'b0, "first_req_timeout");
        chk("first_req_addr", imem_req_addr, 64'h8000_0000);
        wait_for(1'b1, "first_slot_timeout");
        chk("first_inst", 64'(inst), 64'h0010_0093);
        chk("first_inst_pc", inst_pc, 64'h8000_0000);
        consume();
        wait_for(1'b0, "second_req_timeout");
        chk("second_req_addr", imem_req_addr, 64'h8000_0004);

        // Decoder stall: slot must hold with no new request.
        wait_for(1'b1, "stall_slot_timeout");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_inst_valid", 64'(inst_valid), 64'd1);
            chk("stall_inst_pc", inst_pc, 64'h8000_0004);
            chk("stall_no_req", 64'(imem_req_valid), 64'd0);
        end
        consume();
        wait_for(1'b0, "post_stall_req_timeout");
        chk("post_stall_req_addr", imem_req_addr, 64'h8000_0008);

        // Redirect and consume in the same HOLD cycle.
        wait_for(1'b1, "redir_hold_slot_timeout");
        chk("redir_hold_pc", inst_pc, 64'h8000_0008);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0040;
        step();
        inst_ready = 1'b0;
        wait_for(1'b0, "redir_hold_req_timeout");
        chk("redir_hold_req_addr", imem_req_addr, 64'h8000_0040);

        // Redirect while WAIT with a slow response that must be dropped.
        lat = 3;
        step();
        chk("wait_no_slot", 64'(inst_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        wait_for(1'b0, "redir_wait_req_timeout");
        chk("redir_wait_req_addr", imem_req_addr, 64'h8000_0100);
        lat = 1;
        wait_for(1'b1, "redir_wait_slot_timeout");
        chk("redir_wait_inst_pc", inst_pc, 64'h8000_0100);

        // Misaligned redirect target produces a fault slot with no memory traffic.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        step();
        chk("misalign_no_req", 64'(imem_req_valid), 64'd0);
        wait_for(1'b1, "misalign_slot_timeout");
        chk("misalign_fault", 64'(fetch_fault), 64'd1);
        chk("misalign_inst", 64'(inst), 64'h0000_0013);
        chk("misalign_inst_pc", inst_pc, 64'h8000_0102);
        consume();
        wait_for(1'b1, "misalign2_slot_timeout");
        chk("misalign2_inst_pc", inst_pc, 64'h8000_0106);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        wait_for(1'b1, "wrap_slot_timeout");
        chk("wrap_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        consume();
        wait_for(1'b0, "wrap_req_timeout");
        chk("wrap_req_addr", imem_req_addr, 64'd0);

        // Asynchronous reset while a request is outstanding.
        lat = 4;
        step();
        chk("pre_rst_in_wait", 64'(imem_req_valid), 64'd0);
        #1 rst = 1'b1;
        #1;
        chk("arst_req_valid", 64'(imem_req_valid), 64'd1);
        chk("arst_req_addr", imem_req_addr, 64'h8000_0000);
        chk("arst_inst_valid", 64'(inst_valid), 64'd0);
        chk("arst_inst", 64'(inst), 64'd0);
        chk("arst_inst_pc", inst_pc, 64'd0);
        chk("arst_fault", 64'(fetch_fault), 64'd0);
        step();
        rst = 1'b0;
        lat = 1;
        wait_for(1'b0, "post_rst_req_timeout");
        chk("post_rst_req_addr", imem_req_addr, 64'h8000_0000);

        // Randomized traffic against the model.
        slots   = 0;
        rand_on = 1'b1;
        repeat (3000) step();
        rand_on    = 1'b0;
        inst_ready = 1'b0;
        chk("random_progress", 64'(slots >= 100), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
